// File: rtl/pipelined_adder_pkg.sv
// Shared defaults for the segmented pipelined adder and the stage-count derivation.
package pipelined_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;

    function automatic int stages_of(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/pipelined_adder_seg_adder.sv
// Combinational SEG-bit ripple-carry adder built from a chain of full-adder cells.
module seg_adder
    import pipelined_adder_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] x_i,
    input  logic [SEG-1:0] y_i,
    input  logic           cin_i,
    output logic [SEG-1:0] sum_o,
    output logic           cout_o
);

    logic [SEG:0] carry;

    assign carry[0] = cin_i;

    genvar gi;
    generate
        for (gi = 0; gi < SEG; gi++) begin : g_fa
            assign sum_o[gi]     = x_i[gi] ^ y_i[gi] ^ carry[gi];
            assign carry[gi + 1] = (x_i[gi] & y_i[gi]) | (carry[gi] & (x_i[gi] ^ y_i[gi]));
        end
    endgenerate

    assign cout_o = carry[SEG];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract pipelined as SEG-bit ripple segments, one per stage,
// with a registered carry between stages and a valid/ready handshake on both sides.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int STAGES = stages_of(WIDTH, SEG);
    localparam int LAST   = STAGES - 1;

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    // Subtraction is A + ~B + 1; the +1 comes in as the stage-0 carry.
    assign b_eff = b_i ^ {WIDTH{sub_i}};

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int RES_W = (gi + 1) * SEG;

            logic [SEG-1:0]   x;
            logic [SEG-1:0]   y;
            logic [SEG-1:0]   s;
            logic             ci;
            logic             co;
            logic             valid_d;
            logic             valid_q;
            logic [RES_W-1:0] res_d;
            logic [RES_W-1:0] res_q;

            seg_adder #(.SEG(SEG)) u_seg (
                .x_i   (x),
                .y_i   (y),
                .cin_i (ci),
                .sum_o (s),
                .cout_o(co)
            );

            if (gi == 0) begin : g_head
                assign x       = a_i[SEG-1:0];
                assign y       = b_eff[SEG-1:0];
                assign ci      = sub_i | cin_i;
                assign valid_d = in_valid_i;
                assign res_d   = s;
            end else begin : g_body
                assign x       = g_stage[gi-1].g_skew.opa_q[SEG-1:0];
                assign y       = g_stage[gi-1].g_skew.opb_q[SEG-1:0];
                assign ci      = g_stage[gi-1].g_skew.carry_q;
                assign valid_d = g_stage[gi-1].valid_q;
                // Lower result segments ride along so the full sum leaves aligned.
                assign res_d   = {s, g_stage[gi-1].res_q};
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                    res_q   <= '0;
                end else if (adv) begin
                    valid_q <= valid_d;
                    res_q   <= res_d;
                end
            end

            if (gi < LAST) begin : g_skew
                localparam int OP_W = WIDTH - RES_W;

                logic [OP_W-1:0] opa_d;
                logic [OP_W-1:0] opb_d;
                logic [OP_W-1:0] opa_q;
                logic [OP_W-1:0] opb_q;
                logic            carry_q;

                // Upper operand segments wait here until their carry arrives.
                if (gi == 0) begin : g_src_in
                    assign opa_d = a_i[WIDTH-1:SEG];
                    assign opb_d = b_eff[WIDTH-1:SEG];
                end else begin : g_src_skew
                    assign opa_d = g_stage[gi-1].g_skew.opa_q[WIDTH-gi*SEG-1:SEG];
                    assign opb_d = g_stage[gi-1].g_skew.opb_q[WIDTH-gi*SEG-1:SEG];
                end

                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        opa_q   <= '0;
                        opb_q   <= '0;
                        carry_q <= 1'b0;
                    end else if (adv) begin
                        opa_q   <= opa_d;
                        opb_q   <= opb_d;
                        carry_q <= co;
                    end
                end
            end else begin : g_tail
                logic cout_q;
                logic ovf_d;
                logic ovf_q;

                assign ovf_d = (x[SEG-1] == y[SEG-1]) && (s[SEG-1] != x[SEG-1]);

                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                    end else if (adv) begin
                        cout_q <= co;
                        ovf_q  <= ovf_d;
                    end
                end
            end
        end
    endgenerate

    assign out_valid_o = g_stage[LAST].valid_q;
    assign sum_o       = g_stage[LAST].res_q;
    assign cout_o      = g_stage[LAST].g_tail.cout_q;
    assign ovf_o       = g_stage[LAST].g_tail.ovf_q;

    // The whole pipe moves together whenever the output slot can be vacated.
    assign adv        = out_ready_i || !out_valid_o;
    assign in_ready_o = adv;

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised and directed checks of pipelined_adder against an arithmetic reference model.
module tb_pipelined_adder;

    localparam int W      = 16;
    localparam int SEGW   = 4;
    localparam int STAGES = W / SEGW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic         cout;
    logic         ovf;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;

    int checks    = 0;
    int errors    = 0;
    int adv_ctr   = 0;
    int accepted  = 0;
    int delivered = 0;

    // Expected results as {cout, ovf, sum}, with the advance count at acceptance.
    logic [W+1:0] exp_q[$];
    int           at_q[$];
    logic         exp_ov;
    logic [W+1:0] head;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .SEG(SEGW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .cin_i      (cin),
        .sub_i      (sub),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .sum_o      (sum),
        .cout_o     (cout),
        .ovf_o      (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                           input logic fc, input logic fs);
        logic [W-1:0] bp;
        logic [W:0]   full;
        logic         ov;
        bp   = fs ? ~fb : fb;
        full = {1'b0, fa} + {1'b0, bp} + {{W{1'b0}}, (fs | fc)};
        ov   = (fa[W-1] == bp[W-1]) && (full[W-1] != fa[W-1]);
        return {full[W], ov, full[W-1:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_sum", 32'(sum), 32'd0);
            exp_q.delete();
            at_q.delete();
        end else begin
            exp_ov = (exp_q.size() > 0) && (adv_ctr >= at_q[0] + STAGES - 1);
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("in_ready", 32'(in_ready), 32'(out_ready || !exp_ov));
            if (exp_ov) begin
                head = exp_q[0];
                check("sum", 32'(sum), 32'(head[W-1:0]));
                check("cout", 32'(cout), 32'(head[W+1]));
                check("ovf", 32'(ovf), 32'(head[W]));
                if (out_ready) begin
                    $display("xfer %0d sum=%h cout=%b ovf=%b", delivered, sum, cout, ovf);
                    delivered++;
                    void'(exp_q.pop_front());
                    void'(at_q.pop_front());
                end
            end
            if (out_ready || !exp_ov) begin
                adv_ctr++;
                if (in_valid) begin
                    exp_q.push_back(model(a, b, cin, sub));
                    at_q.push_back(adv_ctr);
                    accepted++;
                end
            end
        end
    end

    task automatic rand_op();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic run_lit(input logic [W-1:0] la, input logic [W-1:0] lb, input logic lc,
                           input logic ls, input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        a = la; b = lb; cin = lc; sub = ls; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lit_latency", 32'(lat), 32'(STAGES));
        check("lit_sum", 32'(sum), 32'(es));
        check("lit_cout", 32'(cout), 32'(ec));
        check("lit_ovf", 32'(ovf), 32'(eo));
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [12:0]  ov_seen;
        logic [W+1:0] snap;
        int           cyc;
        int           start_acc;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_cout", 32'(cout), 32'd0);
        #3 rst_n = 1'b1;

        run_lit(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_lit(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_lit(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_lit(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_lit(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_lit(16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        drain();

        // Eight back-to-back operations with the consumer always ready.
        out_ready = 1'b1;
        ov_seen = '0;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            ov_seen[i] = out_valid;
            in_valid = (i < 8);
            if (i < 8) rand_op();
        end
        check("burst_valid_pattern", 32'(ov_seen), 32'h0FF0);
        drain();

        // Fill the pipe, then hold the consumer off for three clocks.
        for (int i = 0; i < STAGES; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            rand_op();
        end
        @(posedge clk); #1;
        snap = {cout, ovf, sum};
        out_ready = 1'b0;
        rand_op();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'({cout, ovf, sum}), 32'(snap));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Random handshakes on both sides.
        start_acc = accepted;
        cyc = 0;
        while (accepted - start_acc < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            rand_op();
            cyc++;
        end
        check("random_ops_done", 32'(accepted - start_acc >= 1000), 32'd1);
        drain();

        // Asynchronous reset with the pipe full.
        for (int i = 0; i < STAGES; i++) begin
            @(posedge clk); #1;
            a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_sum", 32'(sum), 32'd0);
        check("async_rst_cout", 32'(cout), 32'd0);
        check("async_rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        run_lit(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
